multi_counter_arb: RTL and testbench

//  Shares the single inc/inc_addr port of a multi_counter bank among N

---
 rtl/multi_counter_arb.sv | 89 ++++++++
 tb/tb_multi_counter_arb.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/multi_counter_arb.sv
// Round-robin arbiter that funnels N event sources into the single increment
// port of a multi_counter bank, buffering bursts in small saturating counters.
module multi_counter_arb #(
  parameter int N    = 4,
  parameter int AW   = 4,
  parameter int PW   = 3,
  parameter int BASE = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  evt,
  input  logic          ovf_clear,
  output logic          inc,
  output logic [AW-1:0] inc_addr,
  output logic          busy,
  output logic [N-1:0]  overflow
);

  localparam int PTRW = (N > 1) ? $clog2(N) : 1;
  localparam logic [PW-1:0] PEND_MAX = {PW{1'b1}};

  logic [PW-1:0]   pend     [N];
  logic [PW-1:0]   pend_nxt [N];
  logic [PTRW-1:0] ptr;
  logic [PTRW-1:0] win;
  logic [N-1:0]    gnt;
  logic [N-1:0]    drop;
  logic            found;
  logic            busy_nxt;
  int              idx;

  // Round-robin search starting just after the last winner.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the loop can leave it unassigned and infer a latch.
    gnt   = '0;
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && pend[PTRW'(idx)] != '0) begin
        found              = 1'b1;
        gnt[PTRW'(idx)]    = 1'b1;
        win                = PTRW'(idx);
      end
    end
  end

  // Per-source pending update; an arrival at saturation without a grant is lost.
  always_comb begin
    busy_nxt = 1'b0;
    drop     = '0;
    for (int i = 0; i < N; i++) begin
      pend_nxt[i] = pend[i];
      if (evt[i] && !gnt[i]) begin
        if (pend[i] == PEND_MAX) drop[i] = 1'b1;
        else                     pend_nxt[i] = pend[i] + 1'b1;
      end else if (!evt[i] && gnt[i]) begin
        pend_nxt[i] = pend[i] - 1'b1;
      end
      busy_nxt = busy_nxt | (pend_nxt[i] != '0);
    end
  end

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) pend[i] <= '0;
      ptr      <= PTRW'(N - 1);
      inc      <= 1'b0;
      inc_addr <= '0;
      busy     <= 1'b0;
      overflow <= '0;
    end else begin
      for (int i = 0; i < N; i++) pend[i] <= pend_nxt[i];
      inc  <= found;
      busy <= busy_nxt;
      if (found) begin
        ptr      <= win;
        inc_addr <= AW'(BASE + int'(win));
      end
      // A drop in the same cycle as a clear keeps its bit set.
      overflow <= (overflow & ~{N{ovf_clear}}) | drop;
    end
  end

endmodule

// File: tb/tb_multi_counter_arb.sv
// Directed bench for multi_counter_arb: a BASE=0 instance plus a BASE=14
// instance for address wrap, with a small counter-bank model on instance A.
module tb_multi_counter_arb;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] evt_a = '0, evt_b = '0;
  logic       ovf_clear_a = 1'b0, ovf_clear_b = 1'b0;
  logic       inc_a, inc_b, busy_a, busy_b;
  logic [3:0] inc_addr_a, inc_addr_b, overflow_a, overflow_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  multi_counter_arb #(.N(4), .AW(4), .PW(3), .BASE(0)) u_dut_a (
    .clk(clk), .rst(rst), .evt(evt_a), .ovf_clear(ovf_clear_a),
    .inc(inc_a), .inc_addr(inc_addr_a), .busy(busy_a), .overflow(overflow_a)
  );

  multi_counter_arb #(.N(4), .AW(4), .PW(3), .BASE(14)) u_dut_b (
    .clk(clk), .rst(rst), .evt(evt_b), .ovf_clear(ovf_clear_b),
    .inc(inc_b), .inc_addr(inc_addr_b), .busy(busy_b), .overflow(overflow_b)
  );

  // Counter-bank model for instance A: one count per inc seen at an edge.
  int cnt_a [16];
  int tot_a;
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) cnt_a[i] = 0;
      tot_a = 0;
    end else if (inc_a) begin
      cnt_a[inc_addr_a] = cnt_a[inc_addr_a] + 1;
      tot_a = tot_a + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    evt_a = '0;
    evt_b = '0;
    tick(2);
    rst = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_inc_a",  32'(inc_a), 32'd0);
    check("rst_addr_a", 32'(inc_addr_a), 32'd0);
    check("rst_busy_a", 32'(busy_a), 32'd0);
    check("rst_ovf_a",  32'(overflow_a), 32'd0);
    check("rst_inc_b",  32'(inc_b), 32'd0);
    check("rst_addr_b", 32'(inc_addr_b), 32'd0);

    // 1: single pulse on source 0
    tick(3);
    evt_a = 4'b0001;
    tick();
    evt_a = '0;
    check("t1_inc_e",   32'(inc_a), 32'd0);
    check("t1_busy_e",  32'(busy_a), 32'd1);
    tick();
    check("t1_inc_e1",  32'(inc_a), 32'd1);
    check("t1_addr_e1", 32'(inc_addr_a), 32'd0);
    check("t1_busy_e1", 32'(busy_a), 32'd0);
    tick();
    check("t1_inc_e2",  32'(inc_a), 32'd0);
    check("t1_addr_hold", 32'(inc_addr_a), 32'd0);
    check("t1_cnt0",    32'(cnt_a[0]), 32'd1);

    // 2: all four at once drain in order 0..3
    do_reset();
    evt_a = 4'b1111;
    tick();
    evt_a = '0;
    check("t2_busy", 32'(busy_a), 32'd1);
    check("t2_inc0", 32'(inc_a), 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("t2_inc_%0d", k),  32'(inc_a), 32'd1);
      check($sformatf("t2_addr_%0d", k), 32'(inc_addr_a), 32'(k));
    end
    tick();
    check("t2_inc_end",  32'(inc_a), 32'd0);
    check("t2_busy_end", 32'(busy_a), 32'd0);
    for (int k = 0; k < 4; k++)
      check($sformatf("t2_cnt_%0d", k), 32'(cnt_a[k]), 32'd1);

    // 3: source 2 continuously active; drain keeps pace, nothing lost
    do_reset();
    evt_a = 4'b0100;
    tick(12);
    check("t3_busy_mid", 32'(busy_a), 32'd1);
    evt_a = '0;
    tick(4);
    check("t3_cnt2", 32'(cnt_a[2]), 32'd12);
    check("t3_tot",  32'(tot_a), 32'd12);
    check("t3_ovf",  32'(overflow_a), 32'd0);
    check("t3_busy", 32'(busy_a), 32'd0);

    // 4: two sources held for 20 cycles; both saturate, drops alternate
    do_reset();
    evt_a = 4'b0011;
    tick(13);
    check("t4_ovf_e13", 32'(overflow_a), 32'd0);
    tick();
    check("t4_ovf_e14", 32'(overflow_a), 32'b0010);
    tick();
    check("t4_ovf_e15", 32'(overflow_a), 32'b0011);
    tick(5);
    evt_a = '0;
    tick(20);
    check("t4_cnt0", 32'(cnt_a[0]), 32'd17);
    check("t4_cnt1", 32'(cnt_a[1]), 32'd16);
    check("t4_tot",  32'(tot_a), 32'd33);
    check("t4_busy", 32'(busy_a), 32'd0);
    check("t4_ovf_sticky", 32'(overflow_a), 32'b0011);
    ovf_clear_a = 1'b1;
    tick();
    ovf_clear_a = 1'b0;
    check("t4_ovf_clr", 32'(overflow_a), 32'd0);

    // 5: BASE=14 wraps source 2 to address 0; clear loses to a same-cycle drop
    do_reset();
    evt_b = 4'b0100;
    tick();
    evt_b = '0;
    tick();
    check("t5_inc",  32'(inc_b), 32'd1);
    check("t5_wrap", 32'(inc_addr_b), 32'd0);
    tick();
    evt_b = 4'b0011;
    tick(2);
    check("t5_addr_src0", 32'(inc_addr_b), 32'd14);
    tick(11);
    check("t5_ovf_e13", 32'(overflow_b), 32'd0);
    tick();
    check("t5_ovf_e14", 32'(overflow_b), 32'b0010);
    tick();
    check("t5_ovf_e15", 32'(overflow_b), 32'b0011);
    ovf_clear_b = 1'b1;
    tick();
    ovf_clear_b = 1'b0;
    evt_b = '0;
    check("t5_clr_vs_drop", 32'(overflow_b), 32'b0010);
    tick(20);

    // 6: reset mid-burst discards pending work and restores pointer
    do_reset();
    evt_a = 4'b1111;
    tick(4);
    check("t6_busy_pre", 32'(busy_a), 32'd1);
    rst   = 1'b1;
    evt_a = '0;
    tick();
    rst = 1'b0;
    check("t6_inc_rst",  32'(inc_a), 32'd0);
    check("t6_busy_rst", 32'(busy_a), 32'd0);
    tick();
    check("t6_inc_after",  32'(inc_a), 32'd0);
    check("t6_busy_after", 32'(busy_a), 32'd0);
    evt_a = 4'b1000;
    tick();
    evt_a = '0;
    tick();
    check("t6_src3_inc",  32'(inc_a), 32'd1);
    check("t6_src3_addr", 32'(inc_addr_a), 32'd3);
    tick(2);
    do_reset();
    evt_a = 4'b1001;
    tick();
    evt_a = '0;
    tick();
    check("t6_first_addr",  32'(inc_addr_a), 32'd0);
    tick();
    check("t6_second_inc",  32'(inc_a), 32'd1);
    check("t6_second_addr", 32'(inc_addr_a), 32'd3);
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
